stream_scaler_simd: RTL

Parametrised SIMD stream scaler, the next generation of the team's 128-bit stream processor: LANES x 32-bit Avalon-ST lanes, a per-lane coefficient, CSR-programmable right shift, and optional saturation. Each lane byte-swaps its input, multiplies by its coefficient, shifts, and byte-swaps the result back. The block sits between an Avalon-ST source such as a DMA read master and an Avalon-ST sink, with an Avalon-MM slave for control.

---
 rtl/stream_scaler_simd.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/stream_scaler_simd.sv
// Purpose: SIMD stream scaler. Per 32-bit lane: byte swap, multiply by a coefficient, shift right, optional saturate, swap back.
// Latency: 3 stages. A beat handshaken in the cycle after edge n is on aso_data after edge n+3.
// Backpressure: ready ripples back combinationally through the stages; a stalled stage holds; bubbles collapse.
// Build option: define STREAM_SCALER_SAT_EN to build saturation and SAT_COUNT.
module stream_scaler_simd #(
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  input  logic                asi_valid,
  input  logic [32*LANES-1:0] asi_data,
  output logic                asi_ready,
  output logic                aso_valid,
  output logic [32*LANES-1:0] aso_data,
  input  logic                aso_ready
);

  localparam int W = 32*LANES;
  localparam logic [31:0] VERSION = 32'h0001_0300;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // control/status registers
  logic        ctrl_bypass;
  logic        ctrl_sat;
  logic [5:0]  ctrl_shift;
  logic [31:0] coeff [LANES];
  logic [31:0] in_count;
  logic [31:0] out_count;
  logic [31:0] sat_count;
  logic [31:0] rd_mux;
  logic        cnt_clr;

  // pipeline state
  logic        v0, v1, v2;
  logic        rdy0, rdy1, rdy2;
  logic [31:0] x0 [LANES];
  logic [63:0] p1 [LANES];
  logic [5:0]  shift1;
  logic [W-1:0] s2_nxt;

  assign rdy2      = !v2 || aso_ready;
  assign rdy1      = !v1 || rdy2;
  assign rdy0      = !v0 || rdy1;
  assign asi_ready = rdy0;
  assign aso_valid = v2;

  assign cnt_clr = avs_write && (avs_address == 4'd5) && avs_writedata[0];

  // CTRL bypass/shift and per-lane coefficient registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_bypass <= 1'b0;
      ctrl_shift  <= 6'd0;
      for (int k = 0; k < LANES; k++) coeff[k] <= 32'd1;
    end else if (avs_write) begin
      if (avs_address == 4'd1) begin
        ctrl_bypass <= avs_writedata[0];
        ctrl_shift  <= avs_writedata[13:8];
      end
      for (int k = 0; k < LANES; k++)
        if (avs_address == 4'(8 + k)) coeff[k] <= avs_writedata;
    end
  end

  // CSR read mux; unmapped addresses and write-only CLEAR read as zero
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      4'd0:    rd_mux = VERSION;
      4'd1:    rd_mux = {18'd0, ctrl_shift, 6'd0, ctrl_sat, ctrl_bypass};
      4'd2:    rd_mux = in_count;
      4'd3:    rd_mux = out_count;
      4'd4:    rd_mux = sat_count;
      default: rd_mux = '0;
    endcase
    for (int k = 0; k < LANES; k++)
      if (avs_address == 4'(8 + k)) rd_mux = coeff[k];
  end

  // registered read response; a same-cycle write is not yet visible here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  // beat counters; a clear overrides an increment in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_count  <= '0;
      out_count <= '0;
    end else if (cnt_clr) begin
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (asi_valid && rdy0) in_count  <= in_count + 32'd1;
      if (v2 && aso_ready)   out_count <= out_count + 32'd1;
    end
  end

  // S0: capture an input beat with each lane byte-swapped to numeric order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0 <= 1'b0;
      for (int k = 0; k < LANES; k++) x0[k] <= '0;
    end else if (rdy0) begin
      v0 <= asi_valid;
      if (asi_valid)
        for (int k = 0; k < LANES; k++) x0[k] <= bswap(asi_data[32*k +: 32]);
    end
  end

  // S1: multiply and snapshot the mode; bypass forces coefficient 1 and shift 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      shift1 <= 6'd0;
      for (int k = 0; k < LANES; k++) p1[k] <= '0;
    end else if (rdy1) begin
      v1 <= v0;
      if (v0) begin
        shift1 <= ctrl_bypass ? 6'd0 : ctrl_shift;
        for (int k = 0; k < LANES; k++)
          p1[k] <= ctrl_bypass ? {32'd0, x0[k]} : ({32'd0, x0[k]} * {32'd0, coeff[k]});
      end
    end
  end

`ifdef STREAM_SCALER_SAT_EN
  logic             sat1;
  logic [LANES-1:0] lane_sat;

  // CTRL sat_en bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              ctrl_sat <= 1'b0;
    else if (avs_write && avs_address == 4'd1) ctrl_sat <= avs_writedata[1];
  end

  // saturation mode travels with the beat into S1; bypass never saturates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          sat1 <= 1'b0;
    else if (rdy1 && v0)   sat1 <= ctrl_sat && !ctrl_bypass;
  end

  // count beats with any saturated lane as they enter the output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        sat_count <= '0;
    else if (cnt_clr)                    sat_count <= '0;
    else if (rdy2 && v1 && (|lane_sat))  sat_count <= sat_count + 32'd1;
  end
`else
  assign ctrl_sat  = 1'b0;
  assign sat_count = '0;
`endif

  // S2 combinational lane logic: shift, optional saturate, swap back
  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef STREAM_SCALER_SAT_EN
    logic [63:0] r;
    assign r           = p1[k] >> shift1;
    assign lane_sat[k] = sat1 && (|r[63:32]);
    assign s2_nxt[32*k +: 32] = bswap(lane_sat[k] ? 32'hFFFF_FFFF : r[31:0]);
`else
    logic [31:0] lo;
    assign lo = 32'(p1[k] >> shift1);
    assign s2_nxt[32*k +: 32] = bswap(lo);
`endif
  end

  // S2: output register, only updated while the output can move
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2       <= 1'b0;
      aso_data <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) aso_data <= s2_nxt;
    end
  end

endmodule
